calc_op_sequencer: RTL



---
 rtl/calc_op_sequencer_if.sv | 24 ++
 rtl/calc_op_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer_if.sv
// Request/response channel between the calculator control FSM and calc_op_sequencer.
// The master drives requests and rsp_ready. The slave (the sequencer) drives everything else.
interface calc_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [34:0] req_acc;
  logic [24:0] req_arg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [34:0] rsp_result;
  logic        rsp_error;
  logic        busy;

  modport master (
    output req_valid, req_op, req_acc, req_arg, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error, busy
  );

  modport slave (
    input  req_valid, req_op, req_acc, req_arg, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error, busy
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer with fixed-point scaling by 1000 for the keypad calculator.
// Define CALC_SEQ_ROUND_EN to make the scaling divide round half away from zero instead of truncating.
module calc_op_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  calc_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_CHECK, S_RESP} state_e;
  typedef enum logic [1:0] {OP_PLUS, OP_MINUS, OP_MUL, OP_DIV} op_e;

  localparam logic signed [64:0] MAX_RESULT = 65'sd9999000;
  localparam logic signed [64:0] MIN_RESULT = -65'sd999000;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Product accumulator during MUL, then the dividend/quotient shift register during DIV.
  logic [63:0] work_q, work_d;
  logic [63:0] mcand_q, mcand_d;
  logic [24:0] mplier_q, mplier_d;
  logic [24:0] divisor_q, divisor_d;
  logic [25:0] rem_q, rem_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic        muldiv_q, muldiv_d;
  logic        dbz_q, dbz_d;
  logic [34:0] result_q, result_d;
  logic        error_q, error_d;

  op_e         req_op_e;
  logic [34:0] acc_abs;
  logic [24:0] arg_abs;
  logic [63:0] acc_abs_w;
  logic [63:0] acc_x1000;
  logic [63:0] div_bias;
  logic [63:0] mul_bias;

  assign req_op_e  = op_e'(bus.req_op);
  assign acc_abs   = bus.req_acc[34] ? 35'(-bus.req_acc) : bus.req_acc;
  assign arg_abs   = bus.req_arg[24] ? 25'(-bus.req_arg) : bus.req_arg;
  assign acc_abs_w = {29'd0, acc_abs};
  assign acc_x1000 = (acc_abs_w << 10) - (acc_abs_w << 4) - (acc_abs_w << 3);

`ifdef CALC_SEQ_ROUND_EN
  assign div_bias = {40'd0, arg_abs[24:1]};
  assign mul_bias = 64'd500;
`else
  assign div_bias = 64'd0;
  assign mul_bias = 64'd0;
`endif

  // Datapath step terms.
  logic [63:0] partial;
  logic [25:0] rem_shift;
  logic [25:0] rem_sub;
  logic        q_bit;
  logic [35:0] add_a, add_b, sum;
  logic signed [64:0] full_s;

  assign partial   = mplier_q[0] ? mcand_q : 64'd0;
  assign rem_shift = {rem_q[24:0], work_q[63]};
  assign q_bit     = rem_shift >= {1'b0, divisor_q};
  assign rem_sub   = rem_shift - {1'b0, divisor_q};
  assign add_a     = {mcand_q[34], mcand_q[34:0]};
  assign add_b     = {{11{mplier_q[24]}}, mplier_q};
  assign sum       = sub_q ? (add_a - add_b) : (add_a + add_b);

  always_comb begin
    if (!muldiv_q)   full_s = $signed({work_q[63], work_q});
    else if (sign_q) full_s = -$signed({1'b0, work_q});
    else             full_s = $signed({1'b0, work_q});
  end

  // State register and datapath registers.
  // NOTE: every register, including the wide datapath, is cleared by rst_n so an aborted op leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      sign_q    <= 1'b0;
      sub_q     <= 1'b0;
      muldiv_q  <= 1'b0;
      dbz_q     <= 1'b0;
      result_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      sign_q    <= sign_d;
      sub_q     <= sub_d;
      muldiv_q  <= muldiv_d;
      dbz_q     <= dbz_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          unique case (req_op_e)
            OP_PLUS, OP_MINUS: state_d = S_ADDSUB;
            OP_MUL:            state_d = S_MUL;
            OP_DIV:            state_d = (bus.req_arg == 25'd0) ? S_ADDSUB : S_DIV;
            default:           state_d = S_IDLE;
          endcase
        end
      end
      S_ADDSUB: state_d = S_CHECK;
      S_MUL:    if (cnt_q == 6'd24) state_d = S_DIV;
      S_DIV:    if (cnt_q == 6'd63) state_d = S_CHECK;
      S_CHECK:  state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-value logic.
  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    sign_d    = sign_q;
    sub_d     = sub_q;
    muldiv_d  = muldiv_q;
    dbz_d     = dbz_q;
    result_d  = result_q;
    error_d   = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          sign_d    = bus.req_acc[34] ^ bus.req_arg[24];
          sub_d     = (req_op_e == OP_MINUS);
          dbz_d     = (req_op_e == OP_DIV) && (bus.req_arg == 25'd0);
          muldiv_d  = (req_op_e == OP_MUL) || ((req_op_e == OP_DIV) && (bus.req_arg != 25'd0));
          cnt_d     = '0;
          rem_d     = '0;
          divisor_d = arg_abs;
          // ADD/SUB reuse mcand/mplier to hold the raw signed operands.
          mcand_d   = {{29{bus.req_acc[34]}}, bus.req_acc};
          mplier_d  = bus.req_arg;
          work_d    = '0;
          if (req_op_e == OP_MUL) begin
            mcand_d  = acc_abs_w;
            mplier_d = arg_abs;
          end else if (req_op_e == OP_DIV) begin
            work_d   = acc_x1000 + div_bias;
          end
        end
      end
      S_ADDSUB: work_d = dbz_q ? 64'd0 : {{28{sum[35]}}, sum};
      S_MUL: begin
        work_d   = work_q + partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd24) begin
          work_d    = work_q + partial + mul_bias;
          cnt_d     = '0;
          rem_d     = '0;
          divisor_d = 25'd1000;
        end
      end
      S_DIV: begin
        work_d = {work_q[62:0], q_bit};
        rem_d  = q_bit ? rem_sub : rem_shift;
        cnt_d  = cnt_q + 6'd1;
      end
      S_CHECK: begin
        result_d = full_s[34:0];
        error_d  = dbz_q || (full_s > MAX_RESULT) || (full_s < MIN_RESULT);
      end
      default: ;
    endcase
  end

  // Outputs: decodes of state_q plus registered result/error.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_error  = error_q;
endmodule
